// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request (EXU), response (WBU) and PMEM port bundle of the LSU.
// The slave modport is the LSU's view; the master modport is the surrounding
// pipeline/memory view.
interface lsu_ctrl_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic            in_ren;
   logic            in_wen;
   logic [XLEN-1:0] in_addr;
   logic [XLEN-1:0] in_wdata;
   logic [1:0]      in_size;
   logic            in_sext;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_rdata;
   logic            out_err;

   logic            mem_valid;
   logic [XLEN-1:0] mem_raddr;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_wen;
   logic [XLEN-1:0] mem_waddr;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wmask;

   modport slave (
      input  in_valid, in_ren, in_wen, in_addr, in_wdata, in_size, in_sext,
      input  out_ready, mem_rdata,
      output in_ready, out_valid, out_rdata, out_err,
      output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output in_valid, in_ren, in_wen, in_addr, in_wdata, in_size, in_sext,
      output out_ready, mem_rdata,
      input  in_ready, out_valid, out_rdata, out_err,
      input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit in front of the PMEM port.
// One request per handshake: IDLE -> ISSUE (single mem_valid pulse) -> WAIT
// (capture one-cycle-latency read data) -> RESP (hold until WBU accepts).
// Optional feature macro: LSU_MISALIGN_CHK_EN -- misaligned half/word accesses
// skip memory and respond with out_err=1, out_rdata=0.
module lsu_ctrl #(
   parameter int         XLEN    = 32,
   parameter logic [1:0] OP_BYTE = 2'd0,
   parameter logic [1:0] OP_HALF = 2'd1,
   parameter logic [1:0] OP_WORD = 2'd2
) (
   input  logic        clk,
   input  logic        rst,
   lsu_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [1:0]      size_q, size_d;
   logic            sext_q, sext_d;
   logic            wen_q, wen_d;
   logic [XLEN-1:0] out_rdata_q, out_rdata_d;
`ifdef LSU_MISALIGN_CHK_EN
   logic            out_err_q, out_err_d;
`endif

   // Shift the addressed lanes down to bit 0, then size-select and extend.
   // Lanes shifted in from beyond lane 3 are zero, so a misaligned access
   // simply loses its out-of-word bytes.
   function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                               input logic [1:0]      off,
                                               input logic [1:0]      size,
                                               input logic            sext);
      logic [XLEN-1:0]    sh;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      sh  = word >> {off, 3'b000};
      b_s = sh[7:0];
      h_s = sh[15:0];
      case (size)
         OP_BYTE: extract = sext ? XLEN'(b_s) : XLEN'(sh[7:0]);
         OP_HALF: extract = sext ? XLEN'(h_s) : XLEN'(sh[15:0]);
         default: extract = sh;
      endcase
   endfunction

   // Byte-lane enables within the 32-bit word; lanes past lane 3 fall off.
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] off);
      logic [3:0] base;
      case (size)
         OP_BYTE: base = 4'b0001;
         OP_HALF: base = 4'b0011;
         default: base = 4'b1111;
      endcase
      lane_mask = base << off;
   endfunction

`ifdef LSU_MISALIGN_CHK_EN
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      case (size)
         OP_BYTE: misaligned = 1'b0;
         OP_HALF: misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction
`endif

   // State and latched-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         sext_q      <= 1'b0;
         wen_q       <= 1'b0;
         out_rdata_q <= '0;
`ifdef LSU_MISALIGN_CHK_EN
         out_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         wen_q       <= wen_d;
         out_rdata_q <= out_rdata_d;
`ifdef LSU_MISALIGN_CHK_EN
         out_err_q   <= out_err_d;
`endif
      end
   end

   // Next-state logic and per-state handshake/strobe outputs.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      size_d        = size_q;
      sext_d        = sext_q;
      wen_d         = wen_q;
      out_rdata_d   = out_rdata_q;
`ifdef LSU_MISALIGN_CHK_EN
      out_err_d     = out_err_q;
`endif
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_wen   = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               addr_d      = bus.in_addr;
               wdata_d     = bus.in_wdata;
               size_d      = bus.in_size;
               sext_d      = bus.in_sext;
               wen_d       = bus.in_wen;
               out_rdata_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
               out_err_d   = 1'b0;
`endif
               if (bus.in_wen || bus.in_ren) begin
`ifdef LSU_MISALIGN_CHK_EN
                  if (misaligned(bus.in_size, bus.in_addr[1:0])) begin
                     out_err_d = 1'b1;
                     state_d   = S_RESP;
                  end else begin
                     state_d   = S_ISSUE;
                  end
`else
                  state_d = S_ISSUE;
`endif
               end else begin
                  // Neither load nor store: answer with zero, touch nothing.
                  state_d = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            bus.mem_valid = 1'b1;
            bus.mem_wen   = wen_q;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            // PMEM clears mem_rdata once mem_valid drops, so capture it now.
            out_rdata_d = wen_q ? '0 : extract(bus.mem_rdata, addr_q[1:0], size_q, sext_q);
            state_d     = S_RESP;
         end
         S_RESP: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.mem_raddr = {addr_q[XLEN-1:2], 2'b00};
   assign bus.mem_waddr = {addr_q[XLEN-1:2], 2'b00};
   assign bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
   assign bus.mem_wmask = {4'b0000, lane_mask(size_q, addr_q[1:0])};
   assign bus.out_rdata = out_rdata_q;
`ifdef LSU_MISALIGN_CHK_EN
   assign bus.out_err   = out_err_q;
`else
   assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a byte-lane reference model,
// a small PMEM model and a per-cycle compare process.
module tb_lsu_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_mem = 1'b1;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int phase    = -1;

   logic [31:0] pmem [0:15];
   logic [31:0] cap_waddr, cap_wdata;
   logic [7:0]  cap_wmask;

   logic        exp_access, exp_wen, exp_err;
   logic [31:0] exp_waddr, exp_wdata, exp_rdata;
   logic [3:0]  exp_mask;

   logic [31:0] last_rdata;
   logic        last_err;

   lsu_ctrl_if bus ();

   lsu_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // PMEM model: one-cycle read latency, zero when not selected, masked writes.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 16; i++) pmem[i] <= 32'h0;
         pmem[0] <= 32'h80FF_1234;
         pmem[1] <= 32'hDEAD_BEEF;
         pmem[2] <= 32'h0123_4567;
         bus.mem_rdata <= 32'h0;
      end else begin
         bus.mem_rdata <= bus.mem_valid ? pmem[bus.mem_raddr[5:2]] : 32'h0;
         if (bus.mem_valid) begin
            pulses <= pulses + 1;
            if (bus.mem_wen) begin
               cap_waddr <= bus.mem_waddr;
               cap_wdata <= bus.mem_wdata;
               cap_wmask <= bus.mem_wmask;
               for (int i = 0; i < 4; i++)
                  if (bus.mem_wmask[i]) pmem[bus.mem_waddr[5:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // Reference model: expected request/response from byte-lane rules.
   task automatic set_model(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic sext);
      int n, o;
      logic [31:0] word, val;
      logic mis;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      o = int'(addr[1:0]);
      word = pmem[addr[5:2]];
      val = 32'h0;
      exp_mask = 4'h0;
      for (int i = 0; i < n; i++)
         if (o + i < 4) begin
            exp_mask[o+i] = 1'b1;
            val[8*i +: 8] = word[8*(o+i) +: 8];
         end
      if (sext && val[8*n-1])
         for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
      mis        = (n == 2 && o % 2 != 0) || (n == 4 && o != 0);
      exp_waddr  = addr & 32'hFFFF_FFFC;
      exp_wdata  = wdata << (8*o);
      exp_wen    = wen;
      exp_access = ren || wen;
      exp_err    = 1'b0;
      exp_rdata  = wen ? 32'h0 : (ren ? val : 32'h0);
`ifdef LSU_MISALIGN_CHK_EN
      if (exp_access && mis) begin
         exp_access = 1'b0;
         exp_err    = 1'b1;
         exp_rdata  = 32'h0;
      end
`else
      if (mis) exp_err = 1'b0;
`endif
   endtask

   // Cycles since acceptance; response window opens at 3 (1 without memory access).
   always @(posedge clk) begin
      if (rst)
         phase <= -1;
      else if (phase < 0) begin
         if (bus.in_valid) phase <= 1;
      end else if (phase >= (exp_access ? 3 : 1) && bus.out_ready)
         phase <= -1;
      else
         phase <= phase + 1;
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst && !load_mem) begin
         if (phase < 0) begin
            chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            chk("idle_mem_valid", 32'(bus.mem_valid), 32'd0);
         end else begin
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (exp_access && phase == 1) begin
               chk("issue_mem_valid", 32'(bus.mem_valid), 32'd1);
               chk("issue_mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
               chk("issue_raddr", bus.mem_raddr, exp_waddr);
               chk("issue_waddr", bus.mem_waddr, exp_waddr);
               if (exp_wen) begin
                  chk("issue_wdata", bus.mem_wdata, exp_wdata);
                  chk("issue_wmask", 32'(bus.mem_wmask), {28'h0, exp_mask});
               end
            end else
               chk("mem_valid_low", 32'(bus.mem_valid), 32'd0);
            chk("out_valid", 32'(bus.out_valid), 32'(phase >= (exp_access ? 3 : 1)));
            if (phase >= (exp_access ? 3 : 1)) begin
               chk("out_rdata", bus.out_rdata, exp_rdata);
               chk("out_err", 32'(bus.out_err), 32'(exp_err));
            end
         end
      end
   end

   task automatic drive_req(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic sext);
      set_model(ren, wen, addr, wdata, size, sext);
      bus.in_valid = 1'b1;
      bus.in_ren   = ren;
      bus.in_wen   = wen;
      bus.in_addr  = addr;
      bus.in_wdata = wdata;
      bus.in_size  = size;
      bus.in_sext  = sext;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      // Junk on the request bus while busy must not disturb the operation.
      bus.in_ren   = 1'b1;
      bus.in_wen   = ~wen;
      bus.in_addr  = 32'h8000_003C;
      bus.in_wdata = 32'hFFFF_FFFF;
      bus.in_size  = 2'd3;
      bus.in_sext  = ~sext;
   endtask

   task automatic wait_resp(input int hold);
      int rs, k;
      rs = exp_access ? 3 : 1;
      k = 0;
      while (phase < rs && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (phase < rs) chk("resp_timeout", 32'(phase), 32'(rs));
      repeat (hold) @(negedge clk);
      last_rdata = bus.out_rdata;
      last_err   = bus.out_err;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic op(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                     input int hold);
      drive_req(ren, wen, addr, wdata, size, sext);
      wait_resp(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bus.in_valid  = 1'b0;
      bus.in_ren    = 1'b0;
      bus.in_wen    = 1'b0;
      bus.in_addr   = 32'h0;
      bus.in_wdata  = 32'h0;
      bus.in_size   = 2'd0;
      bus.in_sext   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      load_mem = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("reset_out_rdata", bus.out_rdata, 32'h0);
      chk("reset_out_err", 32'(bus.out_err), 32'd0);
      @(posedge clk);
      #1;

      p0 = pulses;
      op(1'b1, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0);
      chk("lit_word_load", last_rdata, 32'hDEAD_BEEF);
      chk("lit_word_pulses", 32'(pulses - p0), 32'd1);

      op(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 0);
      chk("lit_byte_sext", last_rdata, 32'hFFFF_FF80);
      op(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 0);
      chk("lit_byte_zext", last_rdata, 32'h0000_0080);

      p0 = pulses;
      op(1'b0, 1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 0);
      chk("lit_hstore_waddr", cap_waddr, 32'h8000_0000);
      chk("lit_hstore_wdata", cap_wdata, 32'hABCD_0000);
      chk("lit_hstore_wmask", 32'(cap_wmask), 32'h0C);
      chk("lit_hstore_pulses", 32'(pulses - p0), 32'd1);
      chk("lit_hstore_rdata", last_rdata, 32'h0);

      op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0);
      chk("lit_word_after_store", last_rdata, 32'hABCD_1234);
      op(1'b1, 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0);
      chk("lit_half_sext", last_rdata, 32'hFFFF_ABCD);

      p0 = pulses;
      op(1'b1, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 5);
      chk("lit_backpressure_rdata", last_rdata, 32'h0123_4567);
      chk("lit_backpressure_pulses", 32'(pulses - p0), 32'd1);

      p0 = pulses;
      op(1'b0, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 1);
      chk("lit_noop_rdata", last_rdata, 32'h0);
      chk("lit_noop_pulses", 32'(pulses - p0), 32'd0);

      p0 = pulses;
      op(1'b0, 1'b1, 32'h8000_0003, 32'h0000_5A5A, 2'd1, 1'b0, 0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("lit_mis_store_err", 32'(last_err), 32'd1);
      chk("lit_mis_store_pulses", 32'(pulses - p0), 32'd0);
`else
      chk("lit_mis_store_wmask", 32'(cap_wmask), 32'h08);
      chk("lit_mis_store_wdata", cap_wdata, 32'h5A00_0000);
      chk("lit_mis_store_pulses", 32'(pulses - p0), 32'd1);
`endif

      p0 = pulses;
      op(1'b1, 1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("lit_mis_load_err", 32'(last_err), 32'd1);
      chk("lit_mis_load_rdata", last_rdata, 32'h0);
      chk("lit_mis_load_pulses", 32'(pulses - p0), 32'd0);
`else
      chk("lit_mis_load_rdata", last_rdata, 32'h005A_CD12);
      op(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b1, 0);
      chk("lit_mis_half_load", last_rdata, 32'h0000_005A);
`endif

      op(1'b0, 1'b1, 32'h8000_0009, 32'h1122_3344, 2'd0, 1'b0, 2);
      chk("lit_bstore_wdata", cap_wdata, 32'h2233_4400);
      chk("lit_bstore_wmask", 32'(cap_wmask), 32'h02);
      op(1'b1, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 0);
      chk("lit_word_after_bstore", last_rdata, 32'h0123_4467);

      // Reset while a load waits for its read data.
      drive_req(1'b1, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
      @(posedge clk);
      #1;
      p0 = pulses;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_mid_out_rdata", bus.out_rdata, 32'h0);
      repeat (5) @(negedge clk);
      chk("rst_mid_no_pulse", 32'(pulses - p0), 32'd0);
      @(posedge clk);
      #1;

      op(1'b1, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0);
      chk("lit_load_after_reset", last_rdata, 32'hDEAD_BEEF);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
